// File: rtl/perf_pkg.sv
// Shared types and helpers for the rasterizer performance counter bank.
package perf_pkg;

  typedef enum logic [2:0] {
    SAMPLE = 3'd0,
    HIT    = 3'd1,
    TRI    = 3'd2,
    CYCLE  = 3'd3,
    IDLE   = 3'd4
  } cnt_idx_t;

  localparam int unsigned NUM_CNT   = 5;
  localparam int unsigned SAT_MAX_W = 64;

  typedef struct packed {
    logic                 ovf;
    logic [SAT_MAX_W-1:0] sum;
  } sat_res_t;

  // Saturating add clamped to w bits (w <= SAT_MAX_W); ovf set when clamped.
  function automatic sat_res_t sat_add(input logic [SAT_MAX_W-1:0] a,
                                       input logic [SAT_MAX_W-1:0] b,
                                       input int unsigned          w);
    logic [SAT_MAX_W:0] full;
    logic [SAT_MAX_W:0] lim;
    sat_res_t           r;
    full = {1'b0, a} + {1'b0, b};
    lim  = ({{SAT_MAX_W{1'b0}}, 1'b1} << w) - {{SAT_MAX_W{1'b0}}, 1'b1};
    if (full > lim) begin
      r.ovf = 1'b1;
      r.sum = lim[SAT_MAX_W-1:0];
    end else begin
      r.ovf = 1'b0;
      r.sum = full[SAT_MAX_W-1:0];
    end
    return r;
  endfunction

endpackage

// File: rtl/perf_delay_pipe.sv
// Synchronous-reset shift register exposing the DEPTH-1 and DEPTH delayed taps.
module perf_delay_pipe #(
  parameter int unsigned WIDTH = 1,
  parameter int unsigned DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din_i,
  output logic [WIDTH-1:0] tap_a_o,
  output logic [WIDTH-1:0] tap_b_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= din_i;
      for (int i = 1; i < int'(DEPTH); i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign tap_b_o = stage_q[DEPTH-1];

  // A zero-cycle tap is the live input.
  generate
    if (DEPTH == 1) begin : g_tap_a_live
      assign tap_a_o = din_i;
    end else begin : g_tap_a_reg
      assign tap_a_o = stage_q[DEPTH-2];
    end
  endgenerate

endmodule

// File: rtl/perf_counter_bank.sv
// Saturating rasterizer perf counters with atomic snapshot/readout and windowed hit/sample summary.
module perf_counter_bank
  import perf_pkg::*;
#(
  parameter int unsigned SIGFIG     = 24,
  parameter int unsigned VERTS      = 3,
  parameter int unsigned AXIS       = 3,
  parameter int unsigned LANES      = 2,
  parameter int unsigned PIPE_DEPTH = 3,
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned WIN_CYC    = 100000
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     en,
  input  logic                                     clear,
  input  logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0]   tri_R16S,
  input  logic                                     validSamp_R16H,
  input  logic [LANES-1:0]                         hit_R18H,
  input  logic                                     snap_req,
  output logic                                     snap_valid,
  input  logic                                     snap_ack,
  input  logic [2:0]                               rd_sel,
  output logic [CNT_W-1:0]                         rd_data,
  output logic [NUM_CNT-1:0]                       ovf,
  output logic                                     win_done,
  output logic [CNT_W-1:0]                         win_samples,
  output logic [CNT_W-1:0]                         win_hits
);

  localparam int unsigned TRI_W = SIGFIG * VERTS * AXIS;
  localparam int unsigned WC_W  = $clog2(WIN_CYC + 1);

  logic             v_d, v_tap_unused;
  logic [TRI_W-1:0] t_a, t_b;

  perf_delay_pipe #(.WIDTH(1), .DEPTH(PIPE_DEPTH)) u_valid_pipe (
    .clk(clk), .rst(rst), .din_i(validSamp_R16H), .tap_a_o(v_tap_unused), .tap_b_o(v_d)
  );

  perf_delay_pipe #(.WIDTH(TRI_W), .DEPTH(PIPE_DEPTH)) u_tri_pipe (
    .clk(clk), .rst(rst), .din_i(tri_R16S), .tap_a_o(t_a), .tap_b_o(t_b)
  );

  logic [CNT_W-1:0]   cnt_q [NUM_CNT];
  logic [CNT_W-1:0]   cnt_d [NUM_CNT];
  logic [CNT_W-1:0]   evt_cnt [NUM_CNT];
  logic [CNT_W-1:0]   inc [NUM_CNT];
  logic [CNT_W-1:0]   shadow_q [NUM_CNT];
  logic [CNT_W-1:0]   shadow_d [NUM_CNT];
  logic [NUM_CNT-1:0] ovf_q, ovf_d;
  logic               snap_valid_q, snap_valid_d;
  logic [CNT_W-1:0]   rd_data_q, rd_data_d;
  logic [WC_W-1:0]    wc_q, wc_d;
  logic [CNT_W-1:0]   win_s_q, win_s_d, win_h_q, win_h_d;
  logic               win_done_q, win_done_d;
  logic [CNT_W-1:0]   win_samples_q, win_samples_d, win_hits_q, win_hits_d;
  logic [CNT_W-1:0]   hit_pop;

  // Next-state: event increments, clear, snapshot capture, readout and window.
  always_comb begin
    sat_res_t res;
    sat_res_t ws;
    sat_res_t wh;
    hit_pop = '0;
    for (int l = 0; l < int'(LANES); l++) hit_pop = hit_pop + CNT_W'(hit_R18H[l]);

    inc         = '{default: '0};
    inc[SAMPLE] = v_d ? CNT_W'(LANES) : '0;
    inc[HIT]    = v_d ? hit_pop : '0;
    inc[TRI]    = CNT_W'(t_a != t_b);
    inc[CYCLE]  = CNT_W'(1);
    inc[IDLE]   = CNT_W'(!v_d);

    ovf_d = ovf_q;
    for (int k = 0; k < int'(NUM_CNT); k++) begin
      res        = sat_add(SAT_MAX_W'(cnt_q[k]), SAT_MAX_W'(inc[k]), CNT_W);
      evt_cnt[k] = en ? CNT_W'(res.sum) : cnt_q[k];
      ovf_d[k]   = ovf_q[k] | (en & res.ovf);
      cnt_d[k]   = clear ? '0 : evt_cnt[k];
    end
    if (clear) ovf_d = '0;

    // Snapshot sees this cycle's events before clear takes effect.
    shadow_d     = shadow_q;
    snap_valid_d = snap_valid_q;
    if (!snap_valid_q && snap_req) begin
      shadow_d     = evt_cnt;
      snap_valid_d = 1'b1;
    end else if (snap_valid_q && snap_ack) begin
      snap_valid_d = 1'b0;
    end
    rd_data_d = (rd_sel < 3'(NUM_CNT)) ? shadow_q[rd_sel] : '0;

    ws            = sat_add(SAT_MAX_W'(win_s_q), SAT_MAX_W'(inc[SAMPLE]), CNT_W);
    wh            = sat_add(SAT_MAX_W'(win_h_q), SAT_MAX_W'(inc[HIT]), CNT_W);
    wc_d          = wc_q;
    win_s_d       = win_s_q;
    win_h_d       = win_h_q;
    win_done_d    = 1'b0;
    win_samples_d = win_samples_q;
    win_hits_d    = win_hits_q;
    if (clear) begin
      wc_d    = '0;
      win_s_d = '0;
      win_h_d = '0;
    end else if (en) begin
      if (wc_q == WC_W'(WIN_CYC - 1)) begin
        win_done_d    = 1'b1;
        win_samples_d = CNT_W'(ws.sum);
        win_hits_d    = CNT_W'(wh.sum);
        wc_d          = '0;
        win_s_d       = '0;
        win_h_d       = '0;
      end else begin
        wc_d    = wc_q + WC_W'(1);
        win_s_d = CNT_W'(ws.sum);
        win_h_d = CNT_W'(wh.sum);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q         <= '{default: '0};
      shadow_q      <= '{default: '0};
      ovf_q         <= '0;
      snap_valid_q  <= 1'b0;
      rd_data_q     <= '0;
      wc_q          <= '0;
      win_s_q       <= '0;
      win_h_q       <= '0;
      win_done_q    <= 1'b0;
      win_samples_q <= '0;
      win_hits_q    <= '0;
    end else begin
      cnt_q         <= cnt_d;
      shadow_q      <= shadow_d;
      ovf_q         <= ovf_d;
      snap_valid_q  <= snap_valid_d;
      rd_data_q     <= rd_data_d;
      wc_q          <= wc_d;
      win_s_q       <= win_s_d;
      win_h_q       <= win_h_d;
      win_done_q    <= win_done_d;
      win_samples_q <= win_samples_d;
      win_hits_q    <= win_hits_d;
    end
  end

  assign snap_valid  = snap_valid_q;
  assign rd_data     = rd_data_q;
  assign ovf         = ovf_q;
  assign win_done    = win_done_q;
  assign win_samples = win_samples_q;
  assign win_hits    = win_hits_q;

endmodule
